// File: rtl/multiciclo_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer and the MIPS datapath.
// Ports: opcode/zf/mem_ack come from the datapath and memory; every other signal is a control output.
// Modports: master = sequencer side (drives controls), slave = datapath/memory side.
interface multiciclo_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    // Datapath / memory status
    logic [OP_W-1:0]    opcode;
    logic               zf;
    logic               mem_ack;

    // Memory handshake
    logic               mem_req;
    logic               mem_we;
    logic               iord;

    // Datapath enables and mux selects
    logic               ir_we;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_we;
    logic               reg_dst;
    logic               mem_to_reg;

    // Status
    logic               err;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  opcode, zf, mem_ack,
        output mem_req, mem_we, iord,
        output ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
        output reg_we, reg_dst, mem_to_reg,
        output err, retired
    );

    modport slave (
        output opcode, zf, mem_ack,
        input  mem_req, mem_we, iord,
        input  ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
        input  reg_we, reg_dst, mem_to_reg,
        input  err, retired
    );
endinterface

// File: rtl/multiciclo_ctrl.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory req/ack watchdog and retire counter.
// Ports: clk, rst (sync, active-high), bus (multiciclo_ctrl_if.master) carrying opcode/zf/mem_ack in and all controls out.
// Latency: 2 cycles (j) to 5+ cycles (lw); mem_req is held with stable iord/mem_we until mem_ack or watchdog expiry.
module multiciclo_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    multiciclo_ctrl_if.master  bus
);

    // Opcode encodings (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    // alu_op codes understood by ControladorALU
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    // Mux select encodings
    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_BRT   = 2'b01;
    localparam logic [1:0] PCS_JMP   = 2'b10;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    // The watchdog only ever needs to reach TIMEOUT-1: the cycle that
    // finds it there without an ack is the last one allowed.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              WD_EN   = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OP_W-1:0]   op_q;
    logic [WD_W-1:0]   wdog;
    logic [WD_W-1:0]   wdog_nxt;
    logic [CNT_W-1:0]  retired_q;
    logic              wd_expire;
    logic              retire;
    logic              in_mem_wait;

    // Expiry only matters while waiting on memory; an ack in the same
    // cycle takes precedence in the next-state logic below.
    assign in_mem_wait = (state == S_FETCH) || (state == S_MEM);
    assign wd_expire   = WD_EN && in_mem_wait && (wdog == WD_LAST);

    // Every return to FETCH from a working state ends an instruction;
    // IDLE->FETCH is the start-up fetch and does not count.
    assign retire = (state_nxt == S_FETCH) &&
                    ((state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM)    || (state == S_WB));

    // ------------------------------------------------------------------
    // State register and sequential bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            wdog      <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            wdog  <= wdog_nxt;
            if (state == S_DECODE) begin
                op_q <= bus.opcode;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wdog_nxt  = '0;

        unique case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_nxt = S_DECODE;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end

            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ: state_nxt = S_EXEC;
                    OP_J:                                    state_nxt = S_FETCH;
                    default:                                 state_nxt = S_ERR;
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: state_nxt = S_WB;
                    OP_LW, OP_SW:      state_nxt = S_MEM;
                    OP_BEQ:            state_nxt = S_FETCH;
                    default:           state_nxt = S_ERR;
                endcase
            end

            S_MEM: begin
                if (bus.mem_ack) begin
                    state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wd_expire) begin
                    state_nxt = S_ERR;
                end
            end

            S_WB: begin
                state_nxt = S_FETCH;
            end

            S_ERR: begin
                state_nxt = S_ERR;
            end

            default: begin
                state_nxt = S_ERR;
            end
        endcase

        // Counts consecutive unacknowledged wait cycles in the same state;
        // any state change restarts it from zero.
        if ((state_nxt == state) && in_mem_wait && WD_EN) begin
            wdog_nxt = wdog + WD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic (Moore per state, Mealy on mem_ack in FETCH)
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = PCS_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.alu_op     = ALU_ADD;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.err        = 1'b0;

        unique case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b0;
                // IR load and PC+4 happen only in the ack cycle so that a
                // stalled fetch never disturbs PC or IR.
                if (bus.mem_ack) begin
                    bus.ir_we     = 1'b1;
                    bus.pc_we     = 1'b1;
                    bus.alu_src_a = 1'b0;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.alu_op    = ALU_ADD;
                    bus.pc_src    = PCS_ALU;
                end
            end

            S_DECODE: begin
                // Precompute the branch target PC + (imm<<2) into ALUOut.
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = SRCB_IMM4;
                bus.alu_op    = ALU_ADD;
                if (bus.opcode == OP_J) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = PCS_JMP;
                end
            end

            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                case (op_q)
                    OP_RTYPE: begin
                        bus.alu_src_b = SRCB_REG;
                        bus.alu_op    = ALU_FUNCT;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        bus.alu_src_b = SRCB_IMM;
                        bus.alu_op    = ALU_ADD;
                    end
                    OP_BEQ: begin
                        bus.alu_src_b = SRCB_REG;
                        bus.alu_op    = ALU_SUB;
                        bus.pc_src    = PCS_BRT;
                        bus.pc_we     = bus.zf;
                    end
                    default: begin
                        bus.alu_src_a = 1'b0;
                    end
                endcase
            end

            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = (op_q == OP_SW);
            end

            S_WB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = (op_q == OP_RTYPE);
                bus.mem_to_reg = (op_q == OP_LW);
            end

            S_ERR: begin
                bus.err = 1'b1;
            end

            default: begin
                bus.err = 1'b0;
            end
        endcase
    end

    assign bus.retired = retired_q;

endmodule

// File: tb/tb_multiciclo_ctrl.sv
// Self-checking bench for multiciclo_ctrl: directed scenarios followed by randomized instruction streams.
// Expected per-cycle controls are generated per instruction class from the ISA-level behaviour.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_multiciclo_ctrl;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 3;
    localparam int TMO     = 4;
    localparam int CNT_W   = 2;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multiciclo_ctrl_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus_if ();

    multiciclo_ctrl #(
        .OP_W(OP_W), .ALUOP_W(ALUOP_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic        ack;
        logic [5:0]  opc;
        logic        zf;
        logic [16:0] ctl;
        int          ret;
    } step_t;

    step_t q[$];
    int    n_chk     = 0;
    int    n_fail    = 0;
    int    model_ret = 0;
    string phase     = "init";

    // Control vector: {req,we,iord,ir_we,pc_we,pc_src,a,b,alu_op,reg_we,reg_dst,m2r,err}
    function automatic logic [16:0] mk(
        input logic req, input logic we, input logic iord, input logic irwe,
        input logic pcwe, input logic [1:0] pcs, input logic a, input logic [1:0] b,
        input logic [2:0] op, input logic rwe, input logic rdst, input logic m2r,
        input logic err);
        return {req, we, iord, irwe, pcwe, pcs, a, b, op, rwe, rdst, m2r, err};
    endfunction

    function automatic logic [16:0] obs();
        return {bus_if.mem_req, bus_if.mem_we, bus_if.iord, bus_if.ir_we, bus_if.pc_we,
                bus_if.pc_src, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                bus_if.reg_we, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.err};
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic ack, input logic [5:0] opc, input logic zf,
                        input logic [16:0] ctl, input bit retire_after);
        step_t s;
        s.ack = ack;
        s.opc = opc;
        s.zf  = zf;
        s.ctl = ctl;
        s.ret = model_ret;
        q.push_back(s);
        if (retire_after) model_ret = (model_ret + 1) % (1 << CNT_W);
    endtask

    // Expected cycle sequence for one instruction. fw/mw are the number of
    // unacknowledged wait cycles before the ack in FETCH and MEM.
    task automatic build(input logic [5:0] opc, input logic zf, input int fw, input int mw,
                         output bit to_err);
        bit legal;
        logic [16:0] fwait, mwait;
        to_err = 0;
        fwait = mk(1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        mwait = mk(1,(opc == SW),1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);

        if (fw >= TMO) begin
            repeat (TMO) push(0, rop(), rbit(), fwait, 0);
            to_err = 1;
            return;
        end
        repeat (fw) push(0, rop(), rbit(), fwait, 0);
        push(1, rop(), rbit(), mk(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0), 0);

        if (opc == JMP) begin
            push(rbit(), opc, rbit(), mk(0,0,0,0,1,2'b10,0,2'b11,3'b000,0,0,0,0), 1);
            return;
        end
        push(rbit(), opc, rbit(), mk(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,0,0,0), 0);
        legal = (opc == RT) || (opc == LW) || (opc == SW) || (opc == ADDI) || (opc == BEQ);
        if (!legal) begin
            to_err = 1;
            return;
        end

        if (opc == BEQ) begin
            push(rbit(), rop(), zf, mk(0,0,0,0,zf,2'b01,1,2'b00,3'b001,0,0,0,0), 1);
            return;
        end
        if (opc == RT) push(rbit(), rop(), rbit(), mk(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,0), 0);
        else           push(rbit(), rop(), rbit(), mk(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0), 0);

        if (opc == LW || opc == SW) begin
            if (mw >= TMO) begin
                repeat (TMO) push(0, rop(), rbit(), mwait, 0);
                to_err = 1;
                return;
            end
            repeat (mw) push(0, rop(), rbit(), mwait, 0);
            push(1, rop(), rbit(), mwait, (opc == SW));
            if (opc == SW) return;
        end

        push(rbit(), rop(), rbit(), mk(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,(opc == RT),(opc == LW),0), 1);
    endtask

    // Plays up to n queued cycles, then discards whatever remains.
    task automatic run(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            #1;
            bus_if.mem_ack = s.ack;
            bus_if.opcode  = s.opc;
            bus_if.zf      = s.zf;
            @(negedge clk);
            chk("ctl", 32'(obs()), 32'(s.ctl));
            chk("retired", 32'(bus_if.retired), 32'(s.ret));
            @(posedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        bus_if.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = 0;
        bus_if.mem_ack = rbit();
        bus_if.opcode  = rop();
        @(negedge clk);
        chk("idle_ctl", 32'(obs()), 32'd0);
        chk("idle_retired", 32'(bus_if.retired), 32'd0);
        @(posedge clk);
    endtask

    task automatic do_instr(input logic [5:0] opc, input logic zf, input int fw, input int mw,
                            input int err_n);
        bit e;
        build(opc, zf, fw, mw, e);
        if (e) begin
            repeat (err_n) push(rbit(), rop(), rbit(), mk(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,1), 0);
        end
        run(q.size());
        if (e) do_reset();
    endtask

    initial begin
        bit e;
        logic [5:0] opc;
        int fw, mw;

        rst = 1'b1;
        bus_if.opcode  = '0;
        bus_if.zf      = 1'b0;
        bus_if.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        phase = "t1_lw";
        do_instr(LW, 1'b0, 2, 2, 0);

        phase = "t2_beq";
        do_instr(BEQ, 1'b1, 0, 0, 0);
        do_instr(BEQ, 1'b0, 0, 0, 0);

        phase = "t3_j";
        do_instr(JMP, 1'b0, 0, 0, 0);

        phase = "t4_illegal";
        do_instr(6'b111111, 1'b0, 0, 0, 20);

        phase = "t5_timeout";
        do_instr(LW, 1'b0, 0, TMO, 3);
        do_instr(LW, 1'b0, 1, TMO - 1, 0);
        do_instr(SW, 1'b0, TMO - 1, TMO - 1, 0);
        do_instr(ADDI, 1'b0, TMO, 0, 3);

        phase = "t6_wrap";
        do_reset();
        repeat (4) do_instr(RT, 1'b0, 0, 0, 0);
        build(SW, 1'b0, 0, 3, e);
        run(4);
        do_reset();

        phase = "random";
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    opc = RT;
                2, 8:    opc = LW;
                3:       opc = SW;
                4:       opc = ADDI;
                5, 9:    opc = BEQ;
                6:       opc = JMP;
                default: opc = rop();
            endcase
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 2)) : int'($urandom_range(0, TMO - 1));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 2)) : int'($urandom_range(0, TMO - 1));
            do_instr(opc, rbit(), fw, mw, int'($urandom_range(2, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
